// File: rtl/pc_unit.sv
// Fetch program counter: sequential/branch load, exception vector, deferred ERET
// and text-window fetch-address flag. Define PC_FAULT_LOCK_EN for the sticky fault lock.
module pc_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
  parameter logic [31:0] TEXT_LIMIT = 32'h0000_4FFF,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [WIDTH-1:0] next_pc,
  input  logic             int_req,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic             pc_exp,
  output logic             eret_pending,
  output logic             fault
);

  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] BASE_V  = WIDTH'(TEXT_BASE);
  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(TEXT_LIMIT);
  localparam logic [WIDTH-1:0] VEC_V   = WIDTH'(EXC_VECTOR);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_PEND  = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ret_addr;

  // Fetch-address window and alignment check on the live PC
  assign pc_exp = (pc < BASE_V) || (pc > LIMIT_V) || (pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RUN;
      pc           <= RESET_V;
      ret_addr     <= '0;
      eret_pending <= 1'b0;
      fault        <= 1'b0;
    end else if (int_req || exc_req) begin
      // Vector redirect beats stall, ERET and any lock
      state        <= ST_RUN;
      pc           <= VEC_V;
      eret_pending <= 1'b0;
      fault        <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (eret) begin
            if (!stall) begin
              pc <= epc;
            end else begin
              ret_addr     <= epc;
              state        <= ST_PEND;
              eret_pending <= 1'b1;
            end
          end else if (!stall) begin
`ifdef PC_FAULT_LOCK_EN
            if (pc_exp) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              pc <= next_pc;
            end
`else
            pc <= next_pc;
`endif
          end
        end
        ST_PEND: begin
          // A fresh ERET replaces the deferred return address
          if (eret && !stall) begin
            pc           <= epc;
            state        <= ST_RUN;
            eret_pending <= 1'b0;
          end else if (eret) begin
            ret_addr <= epc;
          end else if (!stall) begin
            pc           <= ret_addr;
            state        <= ST_RUN;
            eret_pending <= 1'b0;
          end
        end
`ifdef PC_FAULT_LOCK_EN
        ST_FAULT: begin
          fault <= 1'b1;
        end
`endif
        default: begin
          state        <= ST_RUN;
          eret_pending <= 1'b0;
          fault        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios then random traffic
// against a behavioural PC model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] next_pc;
  logic        int_req;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic        pc_exp;
  logic        eret_pending;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_pend;
  logic        m_fault;

`ifdef PC_FAULT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .next_pc(next_pc),
    .int_req(int_req), .exc_req(exc_req), .eret(eret), .epc(epc),
    .pc(pc), .pc_exp(pc_exp), .eret_pending(eret_pending), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic out_of_text(input logic [31:0] a);
    return (a < 32'h3000) || (a > 32'h4FFF) || (a % 4 != 0);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc_exp"}, 32'(pc_exp), 32'(out_of_text(m_pc)));
    check({tag, ".pend"}, 32'(eret_pending), 32'(m_pend));
    check({tag, ".fault"}, 32'(fault), 32'(m_fault));
  endtask

  function automatic void model_reset();
    m_pc = 32'h3000; m_ret = '0; m_pend = 1'b0; m_fault = 1'b0;
  endfunction

  // Apply one cycle of inputs, advance the model by the priority rules, then compare
  task automatic step(input string tag, input logic s, input logic ir, input logic er,
                      input logic rt, input logic [31:0] np, input logic [31:0] ep);
    stall = s; int_req = ir; exc_req = er; eret = rt; next_pc = np; epc = ep;
    if (ir || er) begin
      m_pc = 32'h4180; m_pend = 1'b0; m_fault = 1'b0;
    end else if (m_fault) begin
      m_fault = 1'b1;
    end else if (rt) begin
      if (!s) begin m_pc = ep; m_pend = 1'b0; end
      else begin m_ret = ep; m_pend = 1'b1; end
    end else if (m_pend) begin
      if (!s) begin m_pc = m_ret; m_pend = 1'b0; end
    end else if (!s) begin
      if (LOCK && out_of_text(m_pc)) m_fault = 1'b1;
      else m_pc = np;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; int_req = 1'b0; exc_req = 1'b0;
    eret = 1'b0; next_pc = '0; epc = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch
    for (int i = 0; i < 3; i++) step("seq", 1'b0, 1'b0, 1'b0, 1'b0, m_pc + 32'd4, 32'h0);

    // Interrupt overrides stall
    step("stall1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h3100, 32'h0);
    step("int_stall", 1'b1, 1'b1, 1'b0, 1'b0, 32'h3100, 32'h0);

    // Deferred ERET across stalls
    step("eret_def0", 1'b1, 1'b0, 1'b0, 1'b1, 32'h3200, 32'h3010);
    step("eret_def1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h3200, 32'h3ABC);
    step("eret_def2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h3200, 32'h3ABC);
    step("eret_done", 1'b0, 1'b0, 1'b0, 1'b0, 32'h3200, 32'h3ABC);

    // Out-of-window fetch, then lock (or follow) and vector recovery
    step("load5000", 1'b0, 1'b0, 1'b0, 1'b0, 32'h5000, 32'h0);
    step("after5000", 1'b0, 1'b0, 1'b0, 1'b0, 32'h3400, 32'h0);
    step("after5000b", 1'b0, 1'b0, 1'b0, 1'b1, 32'h3404, 32'h3500);
    step("exc_clear", 1'b0, 1'b0, 1'b1, 1'b0, 32'h3408, 32'h0);

    // Same-PC reload, misalignment, exc+eret collision
    step("reload", 1'b0, 1'b0, 1'b0, 1'b0, 32'h4180, 32'h0);
    step("misalign", 1'b0, 1'b0, 1'b0, 1'b0, 32'h3002, 32'h0);
    step("exc_eret", 1'b1, 1'b0, 1'b1, 1'b1, 32'h3000, 32'h3020);

    // Async reset while an ERET is pending
    step("pend_again", 1'b1, 1'b0, 1'b0, 1'b1, 32'h3000, 32'h3040);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    step("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h3044, 32'h0);

    // Random traffic, mostly in-window addresses
    for (int i = 0; i < 400; i++) begin
      logic [31:0] np;
      logic [31:0] ep;
      np = 32'h3000 + ((32'($urandom_range(0, 32'h7FF))) << 2);
      if ($urandom_range(0, 9) == 0) np = $urandom;
      ep = 32'h3000 + ((32'($urandom_range(0, 32'h7FF))) << 2);
      step("rand", 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 7) == 0), np, ep);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
